// File: rtl/vmips_pkg.sv
// Shared encodings for the vector execute block:
// ALU op codes, MSA lane formats and FSM states.
package vmips_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        DF_B = 2'b00,
        DF_H = 2'b01,
        DF_W = 2'b10,
        DF_D = 2'b11
    } df_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int SLICE_W = 32;

endpackage

// File: rtl/vec_slice_alu.sv
// 32-bit combinational slice ALU with lane-segmented
// carry; double format is handled as word.
module vec_slice_alu
    import vmips_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  df,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [1:0]  w_fmt;
    logic        w_sub;
    logic [31:0] w_bx;
    logic [31:0] w_sum;
    logic [31:0] w_slt;

    assign w_fmt = (df == DF_D) ? DF_W : df;
    assign w_sub = (op == ALU_SUB);
    assign w_bx  = w_sub ? ~b : b;

    // byte-wise adder; carry restarts at every lane boundary
    always_comb begin
        logic       c;
        logic [8:0] s;
        c     = 1'b0;
        s     = '0;
        w_sum = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || w_fmt == DF_B || (w_fmt == DF_H && i == 2))
                c = w_sub;
            s = {1'b0, a[8*i +: 8]} + {1'b0, w_bx[8*i +: 8]} + {8'b0, c};
            w_sum[8*i +: 8] = s[7:0];
            c = s[8];
        end
    end

    // signed less-than per lane, zero-extended into the lane
    always_comb begin
        w_slt = '0;
        unique case (w_fmt)
            DF_B: begin
                for (int i = 0; i < 4; i++)
                    w_slt[8*i] = $signed(a[8*i +: 8]) < $signed(b[8*i +: 8]);
            end
            DF_H: begin
                for (int j = 0; j < 2; j++)
                    w_slt[16*j] = $signed(a[16*j +: 16]) < $signed(b[16*j +: 16]);
            end
            default: w_slt[0] = $signed(a) < $signed(b);
        endcase
    end

    // operation select; unused codes pass operand a through
    always_comb begin
        case (op)
            ALU_ADD, ALU_SUB: y = w_sum;
            ALU_AND:          y = a & b;
            ALU_OR:           y = a | b;
            ALU_SLT:          y = w_slt;
            default:          y = a;
        endcase
    end

endmodule

// File: rtl/vec_alu_exec.sv
// Multi-cycle vector ALU: latches a request, runs one
// 32-bit slice per cycle, holds the result until taken.
module vec_alu_exec
    import vmips_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int SLICE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_ctrl,
    input  logic [1:0]      df,
    input  logic [VLEN-1:0] src_a,
    input  logic [VLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] result,
    output logic            df_err
);

    localparam int NSL = VLEN / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    state_e          r_state;
    logic [2:0]      r_op;
    logic [1:0]      r_df;
    logic [VLEN-1:0] r_a;
    logic [VLEN-1:0] r_b;
    logic [VLEN-1:0] r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_err;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_y;

    assign w_a = r_a[r_cnt*SLICE +: 32];
    assign w_b = r_b[r_cnt*SLICE +: 32];

    vec_slice_alu u_alu (
        .op (r_op),
        .df (r_df),
        .a  (w_a),
        .b  (w_b),
        .y  (w_y)
    );

    // control FSM, operand latch and slice-wise result write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_df        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= alu_ctrl;
                        r_df       <= df;
                        r_a        <= src_a;
                        r_b        <= src_b;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                        if (df == DF_D)
                            r_err <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    r_res[r_cnt*SLICE +: 32] <= w_y;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_res;
    assign df_err    = r_err;

endmodule

// File: tb/tb_vec_alu_exec.sv
// Randomized bench for vec_alu_exec against a lane-level
// arithmetic reference model.
module tb_vec_alu_exec;

    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      alu_ctrl = '0;
    logic [1:0]      df = '0;
    logic [VLEN-1:0] src_a = '0;
    logic [VLEN-1:0] src_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [VLEN-1:0] result;
    logic            df_err;

    int   n_chk = 0;
    int   n_err = 0;
    logic m_err = 1'b0;

    vec_alu_exec #(.VLEN(VLEN), .SLICE(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .df        (df),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .df_err    (df_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VLEN-1:0] got,
                       input logic [VLEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VLEN-1:0] rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // lane-by-lane arithmetic on plain integers
    function automatic logic [VLEN-1:0] ref_alu(input logic [2:0] op,
        input logic [1:0] f, input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
        int w;
        longint m, av, bv, sa, sb, r;
        logic [VLEN-1:0] y, ta, tb, t;
        w = (f == 2'd0) ? 8 : (f == 2'd1) ? 16 : 32;
        m = longint'(1) << w;
        y = '0;
        for (int i = 0; i < VLEN / w; i++) begin
            ta = a >> (i * w);
            tb = b >> (i * w);
            av = longint'(ta[63:0]) & (m - 1);
            bv = longint'(tb[63:0]) & (m - 1);
            sa = (av >= m / 2) ? av - m : av;
            sb = (bv >= m / 2) ? bv - m : bv;
            case (op)
                3'd0:    r = (av + bv) % m;
                3'd1:    r = (av - bv + m) % m;
                3'd2:    r = av & bv;
                3'd3:    r = av | bv;
                3'd4:    r = (sa < sb) ? 1 : 0;
                default: r = av;
            endcase
            t = '0;
            t[63:0] = r[63:0];
            y = y | (t << (i * w));
        end
        return y;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] t_op,
        input logic [1:0] t_df, input logic [VLEN-1:0] t_a,
        input logic [VLEN-1:0] t_b, input int bp);
        logic [VLEN-1:0] exp;
        int cyc;
        exp = ref_alu(t_op, t_df, t_a, t_b);
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_rdy"}, in_ready, 1);
        alu_ctrl = t_op;
        df       = t_df;
        src_a    = t_a;
        src_b    = t_b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        if (t_df == 2'd3) m_err = 1'b1;
        alu_ctrl = 3'($urandom);
        df       = 2'($urandom);
        src_a    = rnd_vec();
        src_b    = rnd_vec();
        chk({tag, "_busy"}, {out_valid, in_ready}, 2'b00);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 4);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_err"}, df_err, m_err);
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            src_a    = rnd_vec();
            step();
            chk({tag, "_bp"}, {out_valid, in_ready, result}, {2'b10, exp});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
        step();
        chk({tag, "_hold"}, {out_valid, result}, {1'b0, exp});
    endtask

    initial begin
        logic [2:0] o;
        logic [1:0] f;

        repeat (2) step();
        chk("rst_state", {in_ready, out_valid, df_err}, 3'b100);
        chk("rst_res", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("add_b", 3'd0, 2'd0, {16{8'hFF}}, {16{8'h01}}, 0);
        chk("add_b_zero", result, '0);
        run_op("sub_w", 3'd1, 2'd2, '0, {4{32'h1}}, 10);
        chk("sub_w_ones", result, {4{32'hFFFF_FFFF}});
        run_op("slt_h", 3'd4, 2'd1, {8{16'h8000}}, {8{16'h0001}}, 1);
        chk("slt_h_one", result, {8{16'h0001}});
        run_op("slt_hs", 3'd4, 2'd1, {8{16'h0001}}, {8{16'h8000}}, 0);
        chk("slt_hs_zero", result, '0);
        run_op("and_d", 3'd2, 2'd3, {4{32'hF0F0_F0F0}}, {4{32'hFF00_FF00}}, 2);
        chk("and_d_val", result, {4{32'hF000_F000}});

        for (int n = 0; n < 25; n++) begin
            o = 3'($urandom_range(0, 7));
            f = 2'($urandom_range(0, 3));
            run_op("rnd", o, f, rnd_vec(), rnd_vec(), int'($urandom_range(0, 3)));
        end

        // reset after slice 1 of an in-flight operation
        alu_ctrl = 3'd0;
        df       = 2'd0;
        src_a    = rnd_vec();
        src_b    = rnd_vec();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        m_err = 1'b0;
        #2;
        chk("mid_rst", {out_valid, in_ready, df_err}, 3'b010);
        chk("mid_rst_res", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst", {out_valid, in_ready}, 2'b01);
        end

        for (int n = 0; n < 8; n++) begin
            o = 3'($urandom_range(0, 7));
            f = 2'($urandom_range(0, 2));
            run_op("rnd2", o, f, rnd_vec(), rnd_vec(), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
